// File: rtl/run_sequencer.sv
// run_sequencer: preloads the processor data memory from a byte stream, then
// releases the processor from init, counts RUN cycles and reports completion.
//
// Optional feature macro: RUN_SEQUENCER_TIMEOUT_EN enables the RUN watchdog
// (MAX_CYCLES). When undefined, timeout stays 0 and RUN waits on dut_done.
//
// Ports:
//   CLK, reset_n          clock (posedge), asynchronous active-low reset
//   go                    one-cycle request to start a load-and-run sequence
//   load_valid/ready/last preload stream handshake, last-beat marker
//   load_addr/load_data   preload address and byte
//   mem_wr_en/addr/wr_data data-memory write port (one cycle after each beat)
//   dut_start             processor start/init (high except in RUN)
//   dut_done              processor done flag, observed only in RUN
//   busy                  high outside IDLE and DONE (decoded from state)
//   finished/timeout      run end reason
//   cycle_ct              saturating RUN cycle count
module run_sequencer #(
  parameter int unsigned AW           = 8,
  parameter int unsigned DW           = 8,
  parameter int unsigned START_CYCLES = 2,
  parameter logic [15:0] MAX_CYCLES   = 16'hFFFF
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          go,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic          load_last,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wr_data,
  output logic          dut_start,
  input  logic          dut_done,
  output logic          busy,
  output logic          finished,
  output logic          timeout,
  output logic [15:0]   cycle_ct
);

  localparam int unsigned SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

`ifdef RUN_SEQUENCER_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    INIT = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] init_cnt_q, init_cnt_d;
  logic          load_ready_d, mem_wr_en_d, dut_start_d;
  logic          finished_d, timeout_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wr_data_d;
  logic [15:0]   cycle_ct_d;
  logic          beat;
  logic          wd_hit;

  assign busy = (state_q != IDLE) && (state_q != DONE);

  // State and registered outputs
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      init_cnt_q  <= '0;
      load_ready  <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      dut_start   <= 1'b1;
      finished    <= 1'b0;
      timeout     <= 1'b0;
      cycle_ct    <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      load_ready  <= load_ready_d;
      mem_wr_en   <= mem_wr_en_d;
      mem_addr    <= mem_addr_d;
      mem_wr_data <= mem_wr_data_d;
      dut_start   <= dut_start_d;
      finished    <= finished_d;
      timeout     <= timeout_d;
      cycle_ct    <= cycle_ct_d;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    mem_wr_en_d   = 1'b0;
    mem_addr_d    = mem_addr;
    mem_wr_data_d = mem_wr_data;
    finished_d    = finished;
    timeout_d     = timeout;
    cycle_ct_d    = cycle_ct;
    beat          = load_valid & load_ready;
    wd_hit        = WD_EN && (cycle_ct >= MAX_CYCLES);

    case (state_q)
      IDLE, DONE: begin
        if (go) begin
          state_d    = LOAD;
          finished_d = 1'b0;
          timeout_d  = 1'b0;
          cycle_ct_d = '0;
        end
      end
      LOAD: begin
        if (beat) begin
          mem_wr_en_d   = 1'b1;
          mem_addr_d    = load_addr;
          mem_wr_data_d = load_data;
          if (load_last) begin
            state_d    = INIT;
            init_cnt_d = SW'(START_CYCLES - 1);
          end
        end
      end
      INIT: begin
        if (init_cnt_q == '0) begin
          state_d = RUN;
        end else begin
          init_cnt_d = init_cnt_q - SW'(1);
        end
      end
      RUN: begin
        // done takes priority over the watchdog in the same cycle
        if (dut_done) begin
          state_d    = DONE;
          finished_d = 1'b1;
        end else if (wd_hit) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else if (cycle_ct != 16'hFFFF) begin
          cycle_ct_d = cycle_ct + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    load_ready_d = (state_d == LOAD);
    // processor is held in init everywhere except RUN
    dut_start_d  = (state_d != RUN);
  end

endmodule

// File: tb/tb_run_sequencer.sv
module tb_run_sequencer;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic        go, load_valid, load_last, dut_done;
  logic [7:0]  load_addr, load_data;
  logic        load_ready, mem_wr_en, dut_start, busy, finished, timeout;
  logic [7:0]  mem_addr, mem_wr_data;
  logic [15:0] cycle_ct;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  run_sequencer #(
    .AW(8), .DW(8), .START_CYCLES(2), .MAX_CYCLES(16'd20)
  ) dut (
    .CLK(CLK), .reset_n(reset_n), .go(go),
    .load_valid(load_valid), .load_ready(load_ready), .load_last(load_last),
    .load_addr(load_addr), .load_data(load_data),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .dut_start(dut_start), .dut_done(dut_done), .busy(busy),
    .finished(finished), .timeout(timeout), .cycle_ct(cycle_ct)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Write monitor: every mem_wr_en pulse must match the oldest expected write
  always @(negedge CLK) begin
    if (reset_n && mem_wr_en) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write actual=%0h required=none", {mem_addr, mem_wr_data});
      end else begin
        check("mem_write", {mem_addr, mem_wr_data}, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    load_last  = last;
    exp_q.push_back({a, d});
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic start_seq(input string tag);
    go = 1'b1;
    step();
    go = 1'b0;
    check({tag, "_load_ready"}, load_ready, 1'b1);
    check({tag, "_cleared"}, {finished, timeout, cycle_ct}, 18'h0);
  endtask

  // Steps through the two INIT cycles checking dut_start
  task automatic pass_init(input string tag);
    check({tag, "_start_init1"}, {dut_start, load_ready}, 2'b10);
    step();
    check({tag, "_start_init2"}, dut_start, 1'b1);
    step();
    check({tag, "_start_run"}, dut_start, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; go = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    load_addr = '0; load_data = '0; dut_done = 1'b0;
    step(); step();
    check("reset_state", {dut_start, load_ready, mem_wr_en, mem_addr, mem_wr_data,
                          busy, finished, timeout, cycle_ct}, {1'b1, 35'h0});
    reset_n = 1'b1;
    step();

    // Basic load and run, done on RUN cycle 10
    start_seq("basic");
    beat(8'h00, 8'h11, 1'b0);
    beat(8'h01, 8'h22, 1'b0);
    beat(8'h02, 8'h33, 1'b1);
    pass_init("basic");
    repeat (9) step();
    dut_done = 1'b1;
    step();
    dut_done = 1'b0;
    check("basic_end", {busy, finished, timeout, dut_start}, 4'b0101);
    check("basic_cycle_ct", cycle_ct, 16'd9);

    // Rerun from DONE with a gap in the stream and go pulsed during RUN
    start_seq("gap");
    beat(8'h10, 8'hA1, 1'b0);
    step();
    check("gap_no_write", mem_wr_en, 1'b0);
    beat(8'h11, 8'hB2, 1'b1);
    pass_init("gap");
    go = 1'b1;
    step();
    go = 1'b0;
    check("go_ignored_run", {busy, load_ready, dut_start}, 3'b100);
    step(); step();
    dut_done = 1'b1;
    step();
    dut_done = 1'b0;
    check("gap_end", {finished, timeout}, 2'b10);
    check("gap_cycle_ct", cycle_ct, 16'd3);

    // Early done: ignored in LOAD and INIT, taken in the first RUN cycle
    start_seq("early");
    dut_done = 1'b1;
    beat(8'h20, 8'h5A, 1'b0);
    beat(8'h21, 8'h5B, 1'b1);
    pass_init("early");
    check("early_not_finished", {busy, finished}, 2'b10);
    step();
    dut_done = 1'b0;
    check("early_end", {busy, finished}, 2'b01);
    check("early_cycle_ct", cycle_ct, 16'd0);

    // Watchdog
    start_seq("wd");
    beat(8'h30, 8'h77, 1'b1);
    pass_init("wd");
`ifdef RUN_SEQUENCER_TIMEOUT_EN
    begin
      int n = 0;
      while (busy && n < 40) begin
        step();
        n++;
      end
      check("wd_run_cycles", n, 21);
    end
    check("wd_flags", {busy, finished, timeout}, 3'b001);
    check("wd_cycle_ct", cycle_ct, 16'd20);
`else
    repeat (100) step();
    check("nowd_still_run", {busy, timeout, dut_start}, 3'b100);
    check("nowd_cycle_ct", cycle_ct, 16'd100);
    dut_done = 1'b1;
    step();
    dut_done = 1'b0;
    check("nowd_end", {busy, finished, timeout}, 3'b010);
`endif

    // Reset mid-RUN
    start_seq("rst");
    beat(8'h40, 8'hC3, 1'b1);
    pass_init("rst");
    repeat (5) step();
    check("rst_pre_ct", cycle_ct, 16'd5);
    reset_n = 1'b0;
    #1;
    check("rst_async", {dut_start, load_ready, mem_wr_en, mem_addr, mem_wr_data,
                        busy, finished, timeout, cycle_ct}, {1'b1, 35'h0});
    step();
    reset_n = 1'b1;
    step();

    // Sequence after reset completes normally
    start_seq("post");
    beat(8'h50, 8'hE4, 1'b1);
    pass_init("post");
    repeat (3) step();
    dut_done = 1'b1;
    step();
    dut_done = 1'b0;
    check("post_end", {finished, cycle_ct}, {1'b1, 16'd3});

    step();
    check("writes_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
